// File: rtl/foo_handshake_arbiter.sv
// ----------------------------------------------------------------------------
// foo_handshake_arbiter
//
// Round-robin arbiter that shares one ready/valid output channel among N
// ready/valid requesters. The winning beat is captured in a one-entry output
// register, so every out_* signal comes straight from a flop. Each output beat
// is tagged with the index of the requester that produced it, and completed
// output transfers are counted (wrapping) for monitors and debug.
//
// Ports
//   CLK        in   clock, all state updates on the rising edge
//   RESET      in   synchronous active-high reset
//   in_valid   in   [N]        requester i has a beat
//   in_ready   out  [N]        beat i accepted this cycle (one-hot or zero)
//   in_data    in   [N*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   out_valid  out             output register holds a beat
//   out_ready  in              downstream accepts the held beat
//   out_data   out  [WIDTH]    buffered beat data
//   out_src    out  [SRC_W]    requester index that produced out_data
//   xfer_count out  [COUNT_W]  completed output transfers, wraps
// ----------------------------------------------------------------------------
module foo_handshake_arbiter #(
  parameter  int N       = 3,
  parameter  int WIDTH   = 5,
  parameter  int COUNT_W = 8,
  localparam int SRC_W   = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SRC_W-1:0]     out_src,
  output logic [COUNT_W-1:0]   xfer_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0]   lane [N];
  logic [SRC_W-1:0]   winner;
  logic               found;
  logic               drain;
  logic               space;
  logic               load;

  // Unpack the flat data bus into one lane per requester.
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign lane[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Round-robin scan starting at the pointer. The candidate index is formed
  // one bit wider than SRC_W so ptr+k can be folded back below N without
  // overflow before it is used as a select.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(N)) begin
        sum = sum - (SRC_W+1)'(N);
      end
      idx = sum[SRC_W-1:0];
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Handshake qualifiers. Reset gates load so nothing is granted on a
  // reset cycle, even though the register state itself changes on the edge.
  always_comb begin
    drain = (state_q == ST_FULL) && out_ready;
    space = (state_q == ST_EMPTY) || out_ready;
    load  = space && found && !RESET;
  end

  // Grant: only the winner sees ready, and only when the beat is loaded.
  always_comb begin
    in_ready = '0;
    if (load) begin
      in_ready[winner] = 1'b1;
    end
  end

  // Next-state for the output buffer, round-robin pointer and counter.
  // A drain and a load in the same cycle keep the buffer full with the new
  // beat, giving one beat per cycle. A drain without a load empties the
  // buffer but leaves the last data/src visible.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    count_d = count_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (drain && !load) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load) begin
      data_d = lane[winner];
      src_d  = winner;
      if (winner == SRC_W'(N-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = winner + SRC_W'(1);
      end
    end

    if (drain) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // State registers with synchronous reset; a buffered beat is discarded.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign out_valid  = (state_q == ST_FULL);
  assign out_data   = data_q;
  assign out_src    = src_q;
  assign xfer_count = count_q;

endmodule
